lut_frac_ff: RTL and testbench

Fracturable K-input logic element with serially loaded, double-buffered configuration and optional output flops. It is the next-generation LUT primitive for the fpga250 fabric tile. It evaluates one K-input function or two (K-1)-input functions sharing inputs, and each output can be combinational or registered. A shadow shift chain lets a new configuration be loaded while the current one keeps operating, and an explicit commit switches between them.

---
 rtl/lut_frac_ff.sv | 85 ++++++++
 tb/tb_lut_frac_ff.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_frac_ff.sv
// Fracturable K-input LUT with a serially loaded shadow configuration,
// explicit commit into the active configuration, and per-output optional flops.
module lut_frac_ff #(
   parameter int INPUTS   = 4,
   parameter int MEM_SIZE = 2**INPUTS,
   parameter int CFG_BITS = MEM_SIZE + 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [INPUTS-1:0] addr,
   input  logic              ce,
   input  logic              cfg_en,
   input  logic              cfg_in,
   input  logic              cfg_commit,
   output logic              cfg_out,
   output logic [1:0]        out
);

   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] active_q, active_d;
   logic [1:0]          q_q, q_d;

   logic [MEM_SIZE-1:0] truth;
   logic                frac;
   logic [1:0]          reg_sel;
   logic [INPUTS-2:0]   sub_addr;
   logic                f0, f1;
   logic [1:0]          f;

   assign truth    = active_q[MEM_SIZE-1:0];
   assign frac     = active_q[MEM_SIZE];
   assign reg_sel  = active_q[MEM_SIZE+2:MEM_SIZE+1];
   assign sub_addr = addr[INPUTS-2:0];

   // Commit samples the pre-edge shadow, so a shift on the same edge is not seen.
   always_comb begin
      shadow_d = shadow_q;
      if (cfg_en) begin
         shadow_d = {cfg_in, shadow_q[CFG_BITS-1:1]};
      end
      active_d = active_q;
      if (cfg_commit) begin
         active_d = shadow_q;
      end
   end

   always_comb begin
      f0 = truth[{1'b0, sub_addr}];
      f1 = truth[{1'b1, sub_addr}];
      if (frac) begin
         f = {f1, f0};
      end else begin
         f = addr[INPUTS-1] ? {f1, f1} : {f0, f0};
      end
   end

   always_comb begin
      q_d = q_q;
      if (ce) begin
         q_d = f;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
         q_q      <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         q_q      <= q_d;
      end
   end

   assign cfg_out = shadow_q[0];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_out
         assign out[gi] = reg_sel[gi] ? q_q[gi] : f[gi];
      end
   endgenerate

endmodule

// File: tb/tb_lut_frac_ff.sv
// Directed bench for lut_frac_ff at INPUTS=4: reset, AND4, fractured mode,
// registered outputs, double buffering with the serial chain, and reset mid-load.
module tb_lut_frac_ff;

   localparam int K  = 4;
   localparam int CB = 19;

   localparam logic [CB-1:0] CFG_AND4  = {3'b000, 16'h8000};
   localparam logic [CB-1:0] CFG_FRAC  = {3'b001, 16'hE896};
   localparam logic [CB-1:0] CFG_AREG  = {3'b010, 16'h8000};
   localparam logic [CB-1:0] CFG_OR4   = {3'b000, 16'hFFFE};

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [K-1:0] addr = '0;
   logic         ce = 1'b0;
   logic         cfg_en = 1'b0;
   logic         cfg_in = 1'b0;
   logic         cfg_commit = 1'b0;
   logic         cfg_out;
   logic [1:0]   out;

   int checks = 0;
   int failures = 0;

   lut_frac_ff #(.INPUTS(K)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr      (addr),
      .ce        (ce),
      .cfg_en    (cfg_en),
      .cfg_in    (cfg_in),
      .cfg_commit(cfg_commit),
      .cfg_out   (cfg_out),
      .out       (out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_word(input logic [CB-1:0] w);
      for (int i = 0; i < CB; i++) begin
         cfg_en = 1'b1;
         cfg_in = w[i];
         tick();
      end
      cfg_en = 1'b0;
      cfg_in = 1'b0;
   endtask

   task automatic commit();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      addr       = 4'hF;
      cfg_en     = 1'($urandom_range(0, 1));
      cfg_in     = 1'($urandom_range(0, 1));
      cfg_commit = 1'($urandom_range(0, 1));
      rst_n      = 1'b0;
      #1;
      checks++;
      if (out !== 2'b00) begin
         failures++;
         $display("FAIL reset_out: got %b want 00", out);
      end
      checks++;
      if (cfg_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_cfg_out: got %b want 0", cfg_out);
      end
      tick();
      tick();
      cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (out !== 2'b00) begin
         failures++;
         $display("FAIL reset_release_out: got %b want 00", out);
      end
      $display("test_reset done");
   endtask

   task automatic test_and4();
      logic [1:0] exp;
      shift_word(CFG_AND4);
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         #1;
         checks++;
         if (out !== 2'b00) begin
            failures++;
            $display("FAIL and4_precommit addr=%h: got %b want 00", addr, out);
         end
      end
      commit();
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         exp  = (a == 15) ? 2'b11 : 2'b00;
         #1;
         checks++;
         if (out !== exp) begin
            failures++;
            $display("FAIL and4 addr=%h: got %b want %b", addr, out, exp);
         end
      end
      $display("test_and4 done");
   endtask

   task automatic test_fractured();
      logic [3:0] av [3];
      logic [1:0] ev [3];
      av[0] = 4'b0011; ev[0] = 2'b10;
      av[1] = 4'b1111; ev[1] = 2'b11;
      av[2] = 4'b0001; ev[2] = 2'b01;
      shift_word(CFG_FRAC);
      commit();
      for (int i = 0; i < 3; i++) begin
         addr = av[i];
         #1;
         checks++;
         if (out !== ev[i]) begin
            failures++;
            $display("FAIL frac addr=%b: got %b want %b", addr, out, ev[i]);
         end
      end
      $display("test_fractured done");
   endtask

   task automatic test_registered();
      ce = 1'b0;
      addr = 4'hF;
      shift_word(CFG_AREG);
      commit();
      checks++;
      if (out !== 2'b10) begin
         failures++;
         $display("FAIL reg_ce0: got %b want 10", out);
      end
      ce = 1'b1;
      tick();
      ce = 1'b0;
      checks++;
      if (out !== 2'b11) begin
         failures++;
         $display("FAIL reg_ce1: got %b want 11", out);
      end
      addr = 4'h0;
      tick();
      checks++;
      if (out !== 2'b01) begin
         failures++;
         $display("FAIL reg_hold: got %b want 01", out);
      end
      $display("test_registered done");
   endtask

   task automatic test_double_buffer();
      logic [1:0] exp;
      ce = 1'b0;
      shift_word(CFG_AND4);
      commit();
      // Load OR4 while AND4 stays active; commit lands on the last shift edge.
      for (int k = 0; k < CB; k++) begin
         addr       = 4'(k % 16);
         cfg_en     = 1'b1;
         cfg_in     = CFG_OR4[k];
         cfg_commit = (k == CB - 1);
         exp        = (addr == 4'hF) ? 2'b11 : 2'b00;
         #1;
         checks++;
         if (out !== exp) begin
            failures++;
            $display("FAIL dbuf_out k=%0d addr=%h: got %b want %b", k, addr, out, exp);
         end
         checks++;
         if (cfg_out !== CFG_AND4[k]) begin
            failures++;
            $display("FAIL dbuf_cfg_out k=%0d: got %b want %b", k, cfg_out, CFG_AND4[k]);
         end
         tick();
      end
      cfg_en = 1'b0; cfg_in = 1'b0; cfg_commit = 1'b0;
      checks++;
      if (cfg_out !== CFG_OR4[0]) begin
         failures++;
         $display("FAIL dbuf_chain_b0: got %b want %b", cfg_out, CFG_OR4[0]);
      end
      // Installed word is pre-shift: truth FFFC with frac=1.
      addr = 4'h0; #1;
      checks++;
      if (out !== 2'b10) begin
         failures++;
         $display("FAIL early_commit addr=0: got %b want 10", out);
      end
      addr = 4'h1; #1;
      checks++;
      if (out !== 2'b10) begin
         failures++;
         $display("FAIL early_commit addr=1: got %b want 10", out);
      end
      shift_word(CFG_OR4);
      commit();
      addr = 4'h0; #1;
      checks++;
      if (out !== 2'b00) begin
         failures++;
         $display("FAIL or4 addr=0: got %b want 00", out);
      end
      addr = 4'h5; #1;
      checks++;
      if (out !== 2'b11) begin
         failures++;
         $display("FAIL or4 addr=5: got %b want 11", out);
      end
      addr = 4'hF; #1;
      checks++;
      if (out !== 2'b11) begin
         failures++;
         $display("FAIL or4 addr=F: got %b want 11", out);
      end
      $display("test_double_buffer done");
   endtask

   task automatic test_reset_midload();
      for (int i = 0; i < 10; i++) begin
         cfg_en = 1'b1;
         cfg_in = CFG_AND4[i];
         tick();
      end
      #2;
      rst_n = 1'b0;
      addr  = 4'hF;
      #1;
      checks++;
      if (out !== 2'b00) begin
         failures++;
         $display("FAIL midload_rst_out: got %b want 00", out);
      end
      checks++;
      if (cfg_out !== 1'b0) begin
         failures++;
         $display("FAIL midload_rst_cfg_out: got %b want 0", cfg_out);
      end
      cfg_en = 1'b0; cfg_in = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      shift_word(CFG_AND4);
      commit();
      addr = 4'hF; #1;
      checks++;
      if (out !== 2'b11) begin
         failures++;
         $display("FAIL midload_reload addr=F: got %b want 11", out);
      end
      addr = 4'h7; #1;
      checks++;
      if (out !== 2'b00) begin
         failures++;
         $display("FAIL midload_reload addr=7: got %b want 00", out);
      end
      $display("test_reset_midload done");
   endtask

   initial begin
      test_reset();
      test_and4();
      test_fractured();
      test_registered();
      test_double_buffer();
      test_reset_midload();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
